wb_port_arbiter: RTL and testbench

//  Shares the single general-register-file write port between two writeback

---
 rtl/wb_port_arbiter.sv | 104 ++++++++++
 tb/tb_wb_port_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Purpose : shares the register-file write port between the ALU and LSU/MDU writeback paths.
// Latency : 1 cycle from grant (vld&rdy) to the registered write on wb_rd_*_o.
// Backpres: rdy is combinational from vld and starvation state; ALU has fixed priority
//           unless the LSU has lost STARVE_MAX times in a row.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   alu_wb_{vld_i,rdy_o,idx_i,wdata_i}  ALU writeback request channel
//   lsu_wb_{vld_i,rdy_o,idx_i,wdata_i}  LSU/MDU writeback request channel
//   wb_rd_{en_o,idx_o,wdata_o}          registered register-file write port
module wb_port_arbiter #(
  parameter int unsigned STARVE_MAX    = 4,
  parameter int unsigned REG_IDX_WIDTH = 5,
  parameter int unsigned XLEN          = 32,
  parameter logic [REG_IDX_WIDTH-1:0] REG_X0 = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_wb_vld_i,
  output logic                     alu_wb_rdy_o,
  input  logic [REG_IDX_WIDTH-1:0] alu_wb_idx_i,
  input  logic [XLEN-1:0]          alu_wb_wdata_i,
  input  logic                     lsu_wb_vld_i,
  output logic                     lsu_wb_rdy_o,
  input  logic [REG_IDX_WIDTH-1:0] lsu_wb_idx_i,
  input  logic [XLEN-1:0]          lsu_wb_wdata_i,
  output logic                     wb_rd_en_o,
  output logic [REG_IDX_WIDTH-1:0] wb_rd_idx_o,
  output logic [XLEN-1:0]          wb_rd_wdata_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef struct packed {
    logic [REG_IDX_WIDTH-1:0] idx;
    logic [XLEN-1:0]          wdata;
  } wb_req_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  wb_req_t          out_q, out_d;

  logic    starved;
  logic    alu_gnt;
  logic    lsu_gnt;
  wb_req_t sel_req;

  // Grant logic. Gating with rst_n keeps both rdy low while reset is held,
  // so nothing is accepted that the reset would then silently drop.
  always_comb begin
    starved = lsu_wb_vld_i && (cnt_q == CNT_MAX);
    alu_gnt = rst_n && alu_wb_vld_i && !starved;
    lsu_gnt = rst_n && lsu_wb_vld_i && (!alu_wb_vld_i || starved);
    if (lsu_gnt) begin
      sel_req.idx   = lsu_wb_idx_i;
      sel_req.wdata = lsu_wb_wdata_i;
    end else begin
      sel_req.idx   = alu_wb_idx_i;
      sel_req.wdata = alu_wb_wdata_i;
    end
  end

  assign alu_wb_rdy_o = alu_gnt;
  assign lsu_wb_rdy_o = lsu_gnt;

  // Starvation counter: counts consecutive cycles the LSU was waiting while
  // the ALU took the port; saturates so the forced grant condition is sticky.
  always_comb begin
    cnt_d = cnt_q;
    if (!lsu_wb_vld_i || lsu_gnt) begin
      cnt_d = '0;
    end else if (alu_gnt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output stage: idx/data hold when idle; x0 writes are consumed silently.
  always_comb begin
    out_d = out_q;
    en_d  = 1'b0;
    if (alu_gnt || lsu_gnt) begin
      out_d = sel_req;
      en_d  = (sel_req.idx != REG_X0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
      out_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
      out_q <= out_d;
    end
  end

  assign wb_rd_en_o    = en_q;
  assign wb_rd_idx_o   = out_q.idx;
  assign wb_rd_wdata_o = out_q.wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        alu_wb_vld_i;
  logic        alu_wb_rdy_o;
  logic [4:0]  alu_wb_idx_i;
  logic [31:0] alu_wb_wdata_i;
  logic        lsu_wb_vld_i;
  logic        lsu_wb_rdy_o;
  logic [4:0]  lsu_wb_idx_i;
  logic [31:0] lsu_wb_wdata_i;
  logic        wb_rd_en_o;
  logic [4:0]  wb_rd_idx_o;
  logic [31:0] wb_rd_wdata_o;

  wb_port_arbiter #(
    .STARVE_MAX(STARVE_MAX), .REG_IDX_WIDTH(5), .XLEN(32), .REG_X0(5'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_vld_i(alu_wb_vld_i), .alu_wb_rdy_o(alu_wb_rdy_o),
    .alu_wb_idx_i(alu_wb_idx_i), .alu_wb_wdata_i(alu_wb_wdata_i),
    .lsu_wb_vld_i(lsu_wb_vld_i), .lsu_wb_rdy_o(lsu_wb_rdy_o),
    .lsu_wb_idx_i(lsu_wb_idx_i), .lsu_wb_wdata_i(lsu_wb_wdata_i),
    .wb_rd_en_o(wb_rd_en_o), .wb_rd_idx_o(wb_rd_idx_o), .wb_rd_wdata_o(wb_rd_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  int          m_cnt    = 0;
  logic [4:0]  m_idx    = '0;
  logic [31:0] m_data   = '0;
  logic        obs_lsu_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference grant decision from the bench's own starvation counter.
  function automatic logic [1:0] model_grant(input logic av, input logic lv);
    logic ea, el;
    el = lv && (!av || m_cnt == STARVE_MAX);
    ea = av && !el;
    return {ea, el};
  endfunction

  // One clock cycle: drive, check rdy, queue the expected write, check the
  // write that comes out one edge later.
  task automatic cycle(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic lv, input logic [4:0] li, input logic [31:0] ld,
                       input logic ea, input logic el, input string tag);
    exp_t e;
    alu_wb_vld_i = av; alu_wb_idx_i = ai; alu_wb_wdata_i = ad;
    lsu_wb_vld_i = lv; lsu_wb_idx_i = li; lsu_wb_wdata_i = ld;
    #1;
    obs_lsu_rdy = lsu_wb_rdy_o;
    chk({tag, "_alu_rdy"}, 64'(alu_wb_rdy_o), 64'(ea));
    chk({tag, "_lsu_rdy"}, 64'(lsu_wb_rdy_o), 64'(el));
    chk({tag, "_onehot"}, 64'(alu_wb_rdy_o && lsu_wb_rdy_o), 64'(0));
    e.en = 1'b0;
    if (ea) begin
      m_idx = ai; m_data = ad; e.en = (ai != 5'd0);
    end else if (el) begin
      m_idx = li; m_data = ld; e.en = (li != 5'd0);
    end
    e.idx = m_idx; e.data = m_data;
    sbq.push_back(e);
    if (!lv || el) m_cnt = 0;
    else if (ea && m_cnt < STARVE_MAX) m_cnt++;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, "_en"},   64'(wb_rd_en_o),    64'(e.en));
    chk({tag, "_idx"},  64'(wb_rd_idx_o),   64'(e.idx));
    chk({tag, "_data"}, 64'(wb_rd_wdata_o), 64'(e.data));
  endtask

  initial begin
    logic        pa_v, pl_v;
    logic [4:0]  pa_i, pl_i;
    logic [31:0] pa_d, pl_d;
    logic [1:0]  g;
    int          lsu_wait;

    // Reset state, with requests already presented.
    rst_n = 1'b0;
    alu_wb_vld_i = 1'b1; alu_wb_idx_i = 5'd3; alu_wb_wdata_i = 32'h11;
    lsu_wb_vld_i = 1'b1; lsu_wb_idx_i = 5'd4; lsu_wb_wdata_i = 32'h22;
    #3;
    chk("rst_alu_rdy", 64'(alu_wb_rdy_o), 64'(0));
    chk("rst_lsu_rdy", 64'(lsu_wb_rdy_o), 64'(0));
    chk("rst_en",      64'(wb_rd_en_o),   64'(0));
    chk("rst_idx",     64'(wb_rd_idx_o),  64'(0));
    chk("rst_data",    64'(wb_rd_wdata_o), 64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: ALU only.
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, "t1");

    // 2: both valid; ALU wins 4 times, LSU forced on the 5th, ALU again on the 6th.
    for (int i = 1; i <= 4; i++)
      cycle(1, 5'(i), 32'hA000 + i, 1, 5'd9, 32'h9999, 1, 0, "t2_alu");
    cycle(1, 5'd5, 32'hA005, 1, 5'd9, 32'h9999, 0, 1, "t2_lsu");
    cycle(1, 5'd5, 32'hA005, 1, 5'd10, 32'h8888, 1, 0, "t2_alu6");
    cycle(0, 5'd0, 32'h0, 1, 5'd10, 32'h8888, 0, 1, "t2_drain");

    // 3: LSU write to x0 is accepted but not written; then idx 7; then idle hold.
    cycle(0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0, 1, "t3_x0");
    cycle(0, 5'd0, 32'h0, 1, 5'd7, 32'h1234, 0, 1, "t3_x7");
    cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, "t3_idle");

    // 4: two losses, LSU drops vld for a cycle, counter restarts from 0.
    cycle(1, 5'd2, 32'hB1, 1, 5'd12, 32'hC1, 1, 0, "t4_lose1");
    cycle(1, 5'd3, 32'hB2, 1, 5'd12, 32'hC1, 1, 0, "t4_lose2");
    cycle(1, 5'd4, 32'hB3, 0, 5'd12, 32'hC1, 1, 0, "t4_drop");
    for (int i = 0; i < 4; i++)
      cycle(1, 5'(20 + i), 32'hB4 + i, 1, 5'd13, 32'hC2, 1, 0, "t4_alu");
    cycle(1, 5'd24, 32'hB8, 1, 5'd13, 32'hC2, 0, 1, "t4_lsu");

    // 5: async reset with en=1 and counter at 3.
    for (int i = 0; i < 3; i++)
      cycle(1, 5'(17 + i), 32'hD0 + i, 1, 5'd30, 32'hE0, 1, 0, "t5_pre");
    rst_n = 1'b0;
    #1;
    chk("t5_rst_en",   64'(wb_rd_en_o),    64'(0));
    chk("t5_rst_idx",  64'(wb_rd_idx_o),   64'(0));
    chk("t5_rst_data", 64'(wb_rd_wdata_o), 64'(0));
    chk("t5_rst_ardy", 64'(alu_wb_rdy_o),  64'(0));
    chk("t5_rst_lrdy", 64'(lsu_wb_rdy_o),  64'(0));
    m_cnt = 0; m_idx = '0; m_data = '0; sbq.delete();
    @(posedge clk); #1;
    chk("t5_hold_en", 64'(wb_rd_en_o), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      cycle(1, 5'(1 + i), 32'hF0 + i, 1, 5'd30, 32'hE0, 1, 0, "t5_alu");
    cycle(1, 5'd5, 32'hF4, 1, 5'd30, 32'hE0, 0, 1, "t5_lsu");

    // 6: random requests held until granted.
    pa_v = 0; pl_v = 0; pa_i = '0; pl_i = '0; pa_d = '0; pl_d = '0;
    lsu_wait = 0;
    for (int n = 0; n < 10000; n++) begin
      if (!pa_v) begin
        pa_v = 1'($urandom_range(0, 1)); pa_i = 5'($urandom); pa_d = $urandom;
      end
      if (!pl_v) begin
        pl_v = 1'($urandom_range(0, 3) != 0); pl_i = 5'($urandom); pl_d = $urandom;
      end
      g = model_grant(pa_v, pl_v);
      cycle(pa_v, pa_i, pa_d, pl_v, pl_i, pl_d, g[1], g[0], "t6");
      if (pl_v && !obs_lsu_rdy) lsu_wait++;
      else lsu_wait = 0;
      chk("t6_lsu_wait", 64'(lsu_wait > STARVE_MAX), 64'(0));
      if (g[1]) pa_v = 0;
      if (g[0]) pl_v = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
